// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encoding and counter sizing for serial_subtractor
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter must be able to hold WIDTH-1; a 1-bit operand still gets a 1-bit counter.
   function automatic int cnt_width(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit Full_Subtractor cell (d = a - b - bin)
module Full_Subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference is the parity of the three inputs; a borrow is needed when b+bin exceeds a.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first A-B-borrow unit; SERIAL_SUB_OVF_EN adds signed overflow flag
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             borrow_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             ovf_o
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic             borrow_q;

   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;
   logic [WIDTH-1:0] d_next;

   Full_Subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Next result image: new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
   always_comb begin
      last_bit = (count == LAST_CNT);
      d_next   = (d_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
   end

   // Control FSM and datapath; result outputs only change on the completing edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         count    <= '0;
         a_sr     <= '0;
         b_sr     <= '0;
         d_sr     <= '0;
         borrow_q <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         diff_o   <= '0;
         borrow_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  a_sr     <= a_i;
                  b_sr     <= b_i;
                  d_sr     <= '0;
                  borrow_q <= borrow_i;
                  count    <= '0;
                  state    <= SHIFT;
                  busy_o   <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            end
            SHIFT: begin
               a_sr     <= a_sr >> 1;
               b_sr     <= b_sr >> 1;
               d_sr     <= d_next;
               borrow_q <= cell_bout;
               if (last_bit) begin
                  diff_o   <= d_next;
                  borrow_o <= cell_bout;
                  state    <= DONE;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Signed overflow: borrow into the MSB differs from borrow out of it, captured with the result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
      end else if (state == SHIFT && last_bit) begin
         ovf_o <= borrow_q ^ cell_bout;
      end
   end
`else
   assign ovf_o = 1'b0;
`endif

endmodule
